mysource: RTL and testbench
===========================

// Module: mysource
// PURPOSE
//  - Five-sensor alarm voter. Samples sensor lines A..E each clock and counts how many are high.
//  - Raises ALARM once that count has reached THRESHOLD for HOLD_CYCLES consecutive cycles.
//  - Sits between sensor input conditioning (already synchronous to clk) and the alarm driver/indicator logic.
// PARAMETERS
//  - THRESHOLD    3  minimum number of high sensors that counts as a trip (0..5; 0 = always trip)
//  - HOLD_CYCLES  1  consecutive trip cycles required before ALARM asserts (>=1)
//  - CNT_W        3  width of hold counter; must hold HOLD_CYCLES
// PORTS
//  - clk         in   1  single system clock, rising edge
//  - rst_n       in   1  asynchronous active-low reset
//  - A           in   1  sensor 0, synchronous to clk
//  - B           in   1  sensor 1
//  - C           in   1  sensor 2
//  - D           in   1  sensor 3
//  - E           in   1  sensor 4
//  - ACK         in   1  alarm acknowledge; used only when ALARM_LATCH_EN is defined, otherwise ignored
//  - ALARM       out  1  registered alarm output
//  - ACTIVE_CNT  out  3  registered popcount of {A,B,C,D,E}, range 0..5
// BEHAVIOUR
//  - Clocking and reset: one clock domain. Reset is asynchronous, active-low.
//  - Reset values while rst_n=0: ALARM=0, ACTIVE_CNT=0, hold counter=0.
//  - First active edge after rst_n rises: samples inputs normally.
//  - Reset mid-operation clears all state immediately, including a latched alarm.
//  - Combinational values:
//    - cnt  = A+B+C+D+E (3-bit, no overflow possible)
//    - trip = (cnt >= THRESHOLD)
//  - ACTIVE_CNT <= cnt every edge; latency 1 cycle.
//  - Hold counter:
//    - trip=1: increments, saturating at HOLD_CYCLES.
//    - trip=0: clears to 0 on the same edge.
//  - qualified = trip && (hold_next == HOLD_CYCLES).
//  - ALARM <= qualified every edge.
//    - With HOLD_CYCLES=1, ALARM follows trip with exactly 1 cycle latency.
//    - With HOLD_CYCLES=N, ALARM rises on the Nth consecutive trip edge.
//  - A single-cycle drop of trip restarts the hold count from 0. No hysteresis.
//  - Boundaries:
//    - THRESHOLD=0: ALARM=1 after HOLD_CYCLES edges regardless of inputs.
//    - THRESHOLD>5: ALARM is never asserted.
//  - Default function (THRESHOLD=3): majority-of-5.
//    - ALARM=1 for any input vector with three or more ones.
//    - Over all 32 vectors, 16 produce ALARM=1.
//  - No handshake; no state machine beyond the saturating counter (plus the latch flag below).
// CONFIGURATION
//  - Macro ALARM_LATCH_EN:
//  - Defined: ALARM is sticky.
//    - Set on any edge where qualified=1.
//    - Held until an edge where ACK=1 and qualified=0; that edge clears it.
//    - ACK=1 together with qualified=1: set wins and ALARM stays 1.
//    - Hold counter behaves as without the macro.
//  - Not defined: ALARM = registered qualified, as above; ACK has no effect.
// TESTING
//  - Reset: drive rst_n=0 mid-run while ALARM=1 -> ALARM=0 and ACTIVE_CNT=0 immediately, with no clock edge.
//  - Exhaustive sweep, defaults: apply all 32 ABCDE vectors, one per clock.
//    - Required: ALARM=1 exactly for popcount>=3, e.g. 00111->1, 11000->0, 11111->1.
//    - ACTIVE_CNT matches popcount one cycle later.
//  - Latency: hold 01011 for 1 edge -> ALARM=1 at that edge. Next vector 00001 -> ALARM=0 at the following edge.
//  - HOLD_CYCLES=3:
//    - 10101 for 2 edges then 00000 -> ALARM stays 0.
//    - 10101 for 3 edges -> ALARM=1 on the 3rd edge.
//  - ALARM_LATCH_EN defined:
//    - 11100 for 1 edge then 00000 -> ALARM stays 1.
//    - ACK=1 for 1 edge -> ALARM=0.
//    - ACK=1 with 11111 -> ALARM stays 1.
//  - Parameter edges:
//    - THRESHOLD=0, inputs 00000 -> ALARM=1 after 1 edge.
//    - THRESHOLD=6, inputs 11111 -> ALARM=0 always.

Source files
------------

// File: rtl/mysource.sv
// Five-sensor alarm voter.
// Counts how many of the sensor lines A..E are high each cycle and raises
// ALARM once that count has met THRESHOLD for HOLD_CYCLES consecutive edges.
// Optional build macro: ALARM_LATCH_EN makes ALARM sticky until acknowledged
// via ACK. Without the macro ACK is ignored.
module mysource #(
  parameter int THRESHOLD   = 3,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       ACK,
  output logic       ALARM,
  output logic [2:0] ACTIVE_CNT
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  logic [2:0]       cnt;
  logic             trip;
  logic             qualified;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             alarm_q, alarm_d;
  logic [2:0]       active_cnt_q;

  // Popcount of the sensor lines and the trip decision.
  always_comb begin
    cnt  = 3'(A) + 3'(B) + 3'(C) + 3'(D) + 3'(E);
    trip = (int'(cnt) >= THRESHOLD);
  end

  // Saturating run-length counter of consecutive trip cycles; any miss restarts it.
  always_comb begin
    hold_d = '0;
    if (trip) begin
      if (hold_q == HOLD_MAX) begin
        hold_d = hold_q;
      end else begin
        hold_d = hold_q + CNT_W'(1);
      end
    end
    qualified = trip && (hold_d == HOLD_MAX);
  end

`ifdef ALARM_LATCH_EN
  // Sticky alarm: a qualified cycle sets it and wins over ACK; ACK alone clears it.
  always_comb begin
    alarm_d = alarm_q;
    if (qualified) begin
      alarm_d = 1'b1;
    end else if (ACK) begin
      alarm_d = 1'b0;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = ACK;

  // Non-latching alarm simply registers the qualified condition.
  always_comb begin
    alarm_d = qualified;
  end
`endif

  // State and output registers; reset clears everything including a latched alarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      alarm_q      <= 1'b0;
      active_cnt_q <= 3'd0;
    end else begin
      hold_q       <= hold_d;
      alarm_q      <= alarm_d;
      active_cnt_q <= cnt;
    end
  end

  assign ALARM      = alarm_q;
  assign ACTIVE_CNT = active_cnt_q;

endmodule

// File: tb/tb_mysource.sv
// Randomized and directed bench for mysource across four parameterizations,
// checked against a run-length reference model driven by the sensor vector.
module tb_mysource;

  localparam int N_DUT = 4;
  localparam int THR  [N_DUT] = '{3, 3, 0, 6};
  localparam int HOLD [N_DUT] = '{1, 3, 1, 1};
`ifdef ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic A = 0, B = 0, C = 0, D = 0, E = 0, ACK = 0;
  logic       alarm_w [N_DUT];
  logic [2:0] cnt_w   [N_DUT];

  int checks = 0;
  int failures = 0;

  int m_run   [N_DUT];
  bit m_alarm [N_DUT];
  int m_cnt;

  always #5 clk = ~clk;

  mysource #(.THRESHOLD(3), .HOLD_CYCLES(1), .CNT_W(3)) u_def (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .E(E), .ACK(ACK),
    .ALARM(alarm_w[0]), .ACTIVE_CNT(cnt_w[0]));
  mysource #(.THRESHOLD(3), .HOLD_CYCLES(3), .CNT_W(3)) u_h3 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .E(E), .ACK(ACK),
    .ALARM(alarm_w[1]), .ACTIVE_CNT(cnt_w[1]));
  mysource #(.THRESHOLD(0), .HOLD_CYCLES(1), .CNT_W(3)) u_t0 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .E(E), .ACK(ACK),
    .ALARM(alarm_w[2]), .ACTIVE_CNT(cnt_w[2]));
  mysource #(.THRESHOLD(6), .HOLD_CYCLES(1), .CNT_W(3)) u_t6 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D), .E(E), .ACK(ACK),
    .ALARM(alarm_w[3]), .ACTIVE_CNT(cnt_w[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_DUT; i++) begin
      m_run[i]   = 0;
      m_alarm[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Reference: count ones, track how many consecutive edges the count has met threshold.
  task automatic model_edge(input logic [4:0] vec, input logic ack);
    int ones;
    bit qual;
    ones = $countones(vec);
    for (int i = 0; i < N_DUT; i++) begin
      if (ones >= THR[i]) m_run[i] = (m_run[i] + 1 > HOLD[i]) ? HOLD[i] : m_run[i] + 1;
      else                m_run[i] = 0;
      qual = (ones >= THR[i]) && (m_run[i] == HOLD[i]);
      if (LATCH) m_alarm[i] = qual || (m_alarm[i] && !ack);
      else       m_alarm[i] = qual;
    end
    m_cnt = ones;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("%s_alarm%0d", tag, i), 32'(alarm_w[i]), 32'(m_alarm[i]));
      check($sformatf("%s_cnt%0d", tag, i), 32'(cnt_w[i]), 32'(m_cnt));
    end
  endtask

  // Vector bit 4 maps to A, bit 0 to E, matching the ABCDE notation.
  task automatic step(input logic [4:0] vec, input logic ack, input string tag);
    @(negedge clk);
    {A, B, C, D, E} = vec;
    ACK = ack;
    @(posedge clk);
    model_edge(vec, ack);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 32; v++) step(5'(v), 1'b0, "sweep");

    step(5'b01011, 1'b0, "lat_on");
    check("lat_on_dir", 32'(alarm_w[0]), 32'd1);
    step(5'b00001, 1'b0, "lat_off");
    check("lat_off_dir", 32'(alarm_w[0]) | 32'(LATCH ? 1'b0 : 1'b0), LATCH ? 32'(m_alarm[0]) : 32'd0);

    step(5'b00000, 1'b1, "clr");
    step(5'b10101, 1'b0, "h3a");
    step(5'b10101, 1'b0, "h3b");
    step(5'b00000, 1'b0, "h3c");
    check("h3_short", 32'(alarm_w[1]), 32'd0);
    step(5'b10101, 1'b0, "h3d");
    step(5'b10101, 1'b0, "h3e");
    check("h3_2nd", 32'(alarm_w[1]), 32'd0);
    step(5'b10101, 1'b0, "h3f");
    check("h3_3rd", 32'(alarm_w[1]), 32'd1);

    step(5'b00000, 1'b1, "clr2");
    step(5'b11100, 1'b0, "l_set");
    step(5'b00000, 1'b0, "l_hold");
    check("l_hold_dir", 32'(alarm_w[0]), LATCH ? 32'd1 : 32'd0);
    step(5'b00000, 1'b1, "l_ack");
    check("l_ack_dir", 32'(alarm_w[0]), 32'd0);
    step(5'b11111, 1'b1, "l_ackq");
    check("l_ackq_dir", 32'(alarm_w[0]), 32'd1);
    check("t6_never", 32'(alarm_w[3]), 32'd0);

    // Asynchronous reset while alarms are high, no clock edge in between.
    step(5'b11111, 1'b0, "pre_rst");
    check("pre_rst_dir", 32'(alarm_w[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(5'b00000, 1'b0, "t0_first");
    check("t0_first_dir", 32'(alarm_w[2]), 32'd1);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] rv;
      logic       ra;
      rv = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 7) == 0);
      step(rv, ra, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
